vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 91 +++++++++
 tb/tb_vga_timing_gen.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-clock divider, raster position counters and a one-pixel
// registered output stage producing VGA sync, colour and frame-buffer read address.
module vga_timing_gen #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_ACTIVE    = 400,
    parameter int V_FRONT     = 12,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 35,
    parameter int CLK_DIV     = 2,
    parameter bit HSYNC_POS   = 1'b1,
    parameter bit VSYNC_POS   = 1'b1,
    parameter int SCALE_SHIFT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] pixel_rgb,
    output logic       HSYNC,
    output logic       VSYNC,
    output logic [2:0] VGAR,
    output logic [2:0] VGAG,
    output logic [1:0] VGAB,
    output logic [9:0] read_x,
    output logic [9:0] read_y,
    output logic       read_valid,
    output logic       pix_stb,
    output logic       line_start,
    output logic       next_frame,
    output logic [7:0] frame_cnt
);
    localparam logic [10:0] H_LAST     = 11'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [10:0] H_ACT      = 11'(H_ACTIVE);
    localparam logic [10:0] HS_BEG     = 11'(H_ACTIVE + H_FRONT);
    localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [9:0]  V_LAST     = 10'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0]  V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0]  V_ACT_LAST = 10'(V_ACTIVE - 1);
    localparam logic [9:0]  VS_BEG     = 10'(V_ACTIVE + V_FRONT);
    localparam logic [9:0]  VS_END     = 10'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [3:0]  DIV_LAST   = 4'(CLK_DIV - 1);

    logic [3:0]  div;
    logic [10:0] pos_h, nxt_h;
    logic [9:0]  pos_v, nxt_v;
    logic        h_wrap, nxt_act, hs_act, vs_act;

    assign pix_stb    = en && div == DIV_LAST;
    assign h_wrap     = pos_h == H_LAST;
    assign line_start = pix_stb && h_wrap;
    assign next_frame = line_start && pos_v == V_ACT_LAST;

    always_comb begin
        nxt_h   = h_wrap ? '0 : pos_h + 11'd1;
        nxt_v   = !h_wrap ? pos_v : pos_v == V_LAST ? '0 : pos_v + 10'd1;
        nxt_act = nxt_h < H_ACT && nxt_v < V_ACT;
        hs_act  = pos_h >= HS_BEG && pos_h < HS_END;
        vs_act  = pos_v >= VS_BEG && pos_v < VS_END;
    end

    // read address tracks the position register, so it is loaded from the next position
    always_ff @(posedge clk) begin
        if (rst) begin
            div                 <= '0;
            pos_h               <= '0;
            pos_v               <= '0;
            frame_cnt           <= '0;
            read_x              <= '0;
            read_y              <= '0;
            read_valid          <= 1'b1;
            {VGAR, VGAG, VGAB}  <= '0;
            HSYNC               <= !HSYNC_POS;
            VSYNC               <= !VSYNC_POS;
        end else begin
            div <= pix_stb ? '0 : div + {3'b0, en};
            if (pix_stb) begin
                pos_h              <= nxt_h;
                pos_v              <= nxt_v;
                read_valid         <= nxt_act;
                read_x             <= nxt_act ? 10'(nxt_h >> SCALE_SHIFT) : '0;
                read_y             <= nxt_act ? nxt_v >> SCALE_SHIFT : '0;
                {VGAR, VGAG, VGAB} <= read_valid ? pixel_rgb : '0;
                HSYNC              <= hs_act ? HSYNC_POS : !HSYNC_POS;
                VSYNC              <= vs_act ? VSYNC_POS : !VSYNC_POS;
                frame_cnt          <= frame_cnt + {7'b0, next_frame};
            end
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of a tiny-raster instance cycle by cycle, plus
// line-level timing of the default and single-clock-per-pixel configurations.
module tb_vga_timing_gen;
    logic clk = 1'b0, rst = 1'b1, en = 1'b0;
    logic [7:0] pixel_rgb = 8'h00;
    int n_cmp = 0, n_fail = 0;

    always #5 clk = ~clk;

    logic       hs_s, vs_s, rv_s, stb_s, ls_s, nf_s;
    logic [2:0] r_s, g_s;
    logic [1:0] b_s;
    logic [9:0] rx_s, ry_s;
    logic [7:0] fc_s;
    logic       hs_d, vs_d, rv_d, stb_d, ls_d, nf_d;
    logic [2:0] r_d, g_d;
    logic [1:0] b_d;
    logic [9:0] rx_d, ry_d;
    logic [7:0] fc_d;
    logic       hs_1, vs_1, rv_1, stb_1, ls_1, nf_1;
    logic [2:0] r_1, g_1;
    logic [1:0] b_1;
    logic [9:0] rx_1, ry_1;
    logic [7:0] fc_1;

    // tiny raster: 12 pixels x 8 lines, 2 clks per pixel, 192 clks per frame
    vga_timing_gen #(.H_ACTIVE(6), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
                     .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
                     .CLK_DIV(2), .SCALE_SHIFT(1)) dut_s (
        .clk(clk), .rst(rst), .en(en), .pixel_rgb(pixel_rgb),
        .HSYNC(hs_s), .VSYNC(vs_s), .VGAR(r_s), .VGAG(g_s), .VGAB(b_s),
        .read_x(rx_s), .read_y(ry_s), .read_valid(rv_s), .pix_stb(stb_s),
        .line_start(ls_s), .next_frame(nf_s), .frame_cnt(fc_s));

    vga_timing_gen dut_d (
        .clk(clk), .rst(rst), .en(en), .pixel_rgb(pixel_rgb),
        .HSYNC(hs_d), .VSYNC(vs_d), .VGAR(r_d), .VGAG(g_d), .VGAB(b_d),
        .read_x(rx_d), .read_y(ry_d), .read_valid(rv_d), .pix_stb(stb_d),
        .line_start(ls_d), .next_frame(nf_d), .frame_cnt(fc_d));

    vga_timing_gen #(.CLK_DIV(1), .SCALE_SHIFT(0), .HSYNC_POS(1'b0)) dut_1 (
        .clk(clk), .rst(rst), .en(en), .pixel_rgb(pixel_rgb),
        .HSYNC(hs_1), .VSYNC(vs_1), .VGAR(r_1), .VGAG(g_1), .VGAB(b_1),
        .read_x(rx_1), .read_y(ry_1), .read_valid(rv_1), .pix_stb(stb_1),
        .line_start(ls_1), .next_frame(nf_1), .frame_cnt(fc_1));

    typedef struct packed {
        int         cyc;
        logic [7:0] rgb;
        logic       stb, ls, nf, hs, vs;
        logic [7:0] col;
        logic [9:0] rx, ry;
        logic       rv;
        logic [7:0] fc;
    } vec_t;

    vec_t tbl[19];

    function automatic vec_t mk(int cyc, logic [7:0] rgb, logic stb, logic ls, logic nf,
                                logic hs, logic vs, logic [7:0] col, logic [9:0] rx,
                                logic [9:0] ry, logic rv, logic [7:0] fc);
        return '{cyc, rgb, stb, ls, nf, hs, vs, col, rx, ry, rv, fc};
    endfunction

    function automatic logic [63:0] out_s();
        return {25'b0, hs_s, vs_s, r_s, g_s, b_s, rx_s, ry_s, rv_s, fc_s};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int cyc, npulse, t_last, vs_cnt, k;
    logic prev_nf;
    logic [63:0] snap;
    int t0_d, t0_1, hs_rise1, hs_rise2, hs_w, c_full, c_bad, rx_max_d, ls1_d, ls2_d;
    int h1_low, rx_max_1, ls1_1, ls2_1;
    logic hs_prev;

    initial begin
        // cycle 0 is the first clk after reset; pixel n = cyc/2 sits at (n%12, (n/12)%8)
        tbl[0]  = mk(0,   8'hFF, 0, 0, 0, 0, 0, 8'h00, 0, 0, 1, 0);
        tbl[1]  = mk(1,   8'hFF, 1, 0, 0, 0, 0, 8'h00, 0, 0, 1, 0);
        tbl[2]  = mk(2,   8'hFF, 0, 0, 0, 0, 0, 8'hFF, 0, 0, 1, 0);
        tbl[3]  = mk(5,   8'hA9, 1, 0, 0, 0, 0, 8'hA9, 1, 0, 1, 0);
        tbl[4]  = mk(9,   8'hA9, 1, 0, 0, 0, 0, 8'hA9, 2, 0, 1, 0);
        tbl[5]  = mk(12,  8'hA9, 0, 0, 0, 0, 0, 8'hA9, 0, 0, 0, 0);
        tbl[6]  = mk(14,  8'hA9, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        tbl[7]  = mk(19,  8'hA9, 1, 0, 0, 1, 0, 8'h00, 0, 0, 0, 0);
        tbl[8]  = mk(21,  8'hA9, 1, 0, 0, 1, 0, 8'h00, 0, 0, 0, 0);
        tbl[9]  = mk(23,  8'hA9, 1, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        tbl[10] = mk(24,  8'hA9, 0, 0, 0, 0, 0, 8'h00, 0, 0, 1, 0);
        tbl[11] = mk(48,  8'hA9, 0, 0, 0, 0, 0, 8'h00, 0, 1, 1, 0);
        tbl[12] = mk(95,  8'hA9, 1, 1, 1, 0, 0, 8'h00, 0, 0, 0, 0);
        tbl[13] = mk(96,  8'hA9, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 1);
        tbl[14] = mk(133, 8'hA9, 1, 0, 0, 0, 1, 8'h00, 0, 0, 0, 1);
        tbl[15] = mk(168, 8'hA9, 0, 0, 0, 0, 1, 8'h00, 0, 0, 0, 1);
        tbl[16] = mk(170, 8'hA9, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 1);
        tbl[17] = mk(192, 8'hA9, 0, 0, 0, 0, 0, 8'h00, 0, 0, 1, 1);
        tbl[18] = mk(193, 8'hA9, 1, 0, 0, 0, 0, 8'h00, 0, 0, 1, 1);

        en = 1'b1;
        pixel_rgb = 8'hFF;
        repeat (3) step();
        rst = 1'b0;
        cyc = 0;
        chk("rst_hs_d", hs_d, 0);
        chk("rst_vs_d", vs_d, 0);
        chk("rst_rv_d", rv_d, 1);
        chk("rst_hs_1", hs_1, 1);
        chk("rst_vs_1", vs_1, 0);

        for (int i = 0; i < 19; i++) begin
            pixel_rgb = tbl[i].rgb;
            while (cyc < tbl[i].cyc) begin
                step();
                cyc++;
            end
            chk($sformatf("v%0d.pix_stb", i), stb_s, tbl[i].stb);
            chk($sformatf("v%0d.line_start", i), ls_s, tbl[i].ls);
            chk($sformatf("v%0d.next_frame", i), nf_s, tbl[i].nf);
            chk($sformatf("v%0d.hsync", i), hs_s, tbl[i].hs);
            chk($sformatf("v%0d.vsync", i), vs_s, tbl[i].vs);
            chk($sformatf("v%0d.rgb", i), {r_s, g_s, b_s}, tbl[i].col);
            chk($sformatf("v%0d.read_x", i), rx_s, tbl[i].rx);
            chk($sformatf("v%0d.read_y", i), ry_s, tbl[i].ry);
            chk($sformatf("v%0d.read_valid", i), rv_s, tbl[i].rv);
            chk($sformatf("v%0d.frame_cnt", i), fc_s, tbl[i].fc);
        end

        // hold en low for 37 clks at pixel (2,0), then resume
        while (cyc < 196) begin
            step();
            cyc++;
        end
        snap = out_s();
        en = 1'b0;
        #1;
        for (int i = 0; i < 37; i++) begin
            chk("freeze_strobes", {stb_s, ls_s, nf_s}, 0);
            chk("freeze_outputs", out_s(), snap);
            step();
        end
        en = 1'b1;
        #1;
        chk("resume_stb_lo", stb_s, 0);
        chk("resume_rx_a", rx_s, 1);
        step();
        chk("resume_stb_hi", stb_s, 1);
        chk("resume_rx_b", rx_s, 1);
        repeat (158) step();
        chk("pre_rst_stb", stb_s, 1);
        chk("pre_rst_hs", hs_s, 1);
        chk("pre_rst_vs", vs_s, 1);
        chk("pre_rst_rv", rv_s, 0);
        chk("pre_rst_fc", fc_s, 2);

        // single-clk reset mid-frame with en still high
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_outputs", out_s(), {25'b0, 2'b00, 8'h00, 10'd0, 10'd0, 1'b1, 8'd0});
        chk("mrst_strobes", {stb_s, ls_s, nf_s}, 0);
        step();
        chk("mrst_first_stb", stb_s, 1);
        chk("mrst_first_rx", rx_s, 0);

        // frame counter over 256 frames of the tiny raster
        npulse = 0;
        t_last = 0;
        vs_cnt = 0;
        prev_nf = 1'b0;
        k = 0;
        while (k < 52000) begin
            if (prev_nf && (npulse == 1 || npulse == 3 || npulse == 255 || npulse == 256))
                chk($sformatf("frame_cnt_after_%0d", npulse), fc_s, npulse & 255);
            if (prev_nf && npulse == 256) break;
            if (npulse == 1 && vs_s) vs_cnt++;
            prev_nf = nf_s;
            if (nf_s) begin
                if (npulse >= 1 && npulse <= 3) chk("next_frame_period", k - t_last, 192);
                t_last = k;
                npulse++;
            end
            step();
            k++;
        end
        chk("next_frame_count", npulse, 256);
        chk("vsync_clks_per_frame", vs_cnt, 48);

        // default and CLK_DIV=1 line timing with white pixels
        pixel_rgb = 8'hFF;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        t0_d = -1; t0_1 = -1; hs_rise1 = -1; hs_rise2 = -1; hs_w = 0; c_full = 0; c_bad = 0;
        rx_max_d = 0; ls1_d = -1; ls2_d = -1; h1_low = 0; rx_max_1 = 0; ls1_1 = -1; ls2_1 = -1;
        hs_prev = 1'b0;
        for (int i = 0; i < 3300; i++) begin
            if (stb_d && t0_d < 0) t0_d = i;
            if (stb_1 && t0_1 < 0) t0_1 = i;
            if (hs_d && !hs_prev) begin
                if (hs_rise1 < 0) hs_rise1 = i;
                else if (hs_rise2 < 0) hs_rise2 = i;
            end
            hs_prev = hs_d;
            if (i < 1600 && hs_d) hs_w++;
            if (i < 1600 && {r_d, g_d, b_d} == 8'hFF) c_full++;
            else if (i < 1600 && {r_d, g_d, b_d} != 8'h00) c_bad++;
            if (int'(rx_d) > rx_max_d) rx_max_d = int'(rx_d);
            if (ls_d) begin
                if (ls1_d < 0) ls1_d = i;
                else if (ls2_d < 0) ls2_d = i;
            end
            if (i < 800 && !hs_1) h1_low++;
            if (int'(rx_1) > rx_max_1) rx_max_1 = int'(rx_1);
            if (ls_1) begin
                if (ls1_1 < 0) ls1_1 = i;
                else if (ls2_1 < 0) ls2_1 = i;
            end
            step();
        end
        chk("def_first_stb_cyc", t0_d, 1);
        chk("div1_first_stb_cyc", t0_1, 0);
        chk("def_hs_rise", hs_rise1, 1314);
        chk("def_hs_width", hs_w, 192);
        chk("def_hs_period", hs_rise2 - hs_rise1, 1600);
        chk("def_colour_clks", c_full, 1280);
        chk("def_colour_partial", c_bad, 0);
        chk("def_read_x_max", rx_max_d, 319);
        chk("def_line_period", ls2_d - ls1_d, 1600);
        chk("div1_hs_low_clks", h1_low, 96);
        chk("div1_read_x_max", rx_max_1, 639);
        chk("div1_line_period", ls2_1 - ls1_1, 800);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
